// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions.
// - Default field width and PC reset value for the pipeline registers.
// - Field indices of the W-stage register.
// - Handshake state encoding of the skid-buffered pipeline register.
package cpu_pkg;

  localparam int          DATA_W_DEFAULT = 32;
  localparam logic [31:0] PC_RST_DEFAULT = 32'h0000_3000;

  // W-stage field layout
  localparam int FLD_STR = 0;
  localparam int FLD_PC4 = 1;
  localparam int FLD_ALO = 2;
  localparam int FLD_DMD = 3;

  // Occupancy of the skid-buffered stage: EMPTY (M=0,S=0), ONE (M=1,S=0), FULL (M=1,S=1)
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } skid_state_e;

endpackage

// File: rtl/pipe_stage_skid.sv
// Skid entry and handshake state for the registered-ready pipeline stage.
// Ports:
//   i_clk, i_rst_n      clock, async active-low reset
//   i_clr               synchronous flush (returns to EMPTY)
//   i_vld, i_dat        upstream valid / data
//   i_rdy               downstream ready
//   o_rdy               upstream ready, straight from a flop
//   o_m_vld             main register holds valid data
//   o_ld_in             main register loads i_dat this edge
//   o_ld_skid           main register loads the skid entry this edge
//   o_skid_dat          skid entry contents
//
// state    | meaning
// ST_EMPTY | nothing held, ready
// ST_ONE   | main valid, skid free, ready
// ST_FULL  | main and skid valid, not ready
module pipe_stage_skid
  import cpu_pkg::*;
#(
  parameter int W = 128
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_vld,
  input  logic [W-1:0] i_dat,
  input  logic         i_rdy,
  output logic         o_rdy,
  output logic         o_m_vld,
  output logic         o_ld_in,
  output logic         o_ld_skid,
  output logic [W-1:0] o_skid_dat
);

  skid_state_e r_state;
  skid_state_e w_state_nxt;
  logic        r_rdy;
  logic [W-1:0] r_skid;
  logic        w_up;
  logic        w_ld_skid_entry;

  assign w_up = i_vld & r_rdy;

  always_comb begin
    w_state_nxt     = r_state;
    o_ld_in         = 1'b0;
    o_ld_skid       = 1'b0;
    w_ld_skid_entry = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_up) begin
          w_state_nxt = ST_ONE;
          o_ld_in     = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_up && i_rdy) begin
          o_ld_in = 1'b1;
        end else if (i_rdy) begin
          w_state_nxt = ST_EMPTY;
        end else if (w_up) begin
          w_state_nxt     = ST_FULL;
          w_ld_skid_entry = 1'b1;
        end
      end
      ST_FULL: begin
        if (i_rdy) begin
          w_state_nxt = ST_ONE;
          o_ld_skid   = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    // Flush wins; any coincident upstream beat is swallowed.
    if (i_clr) begin
      w_state_nxt     = ST_EMPTY;
      o_ld_in         = 1'b0;
      o_ld_skid       = 1'b0;
      w_ld_skid_entry = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_EMPTY;
      r_rdy   <= 1'b1;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Ready is precomputed from the next state so no path from i_rdy reaches o_rdy.
      r_rdy   <= (w_state_nxt != ST_FULL);
      if (w_ld_skid_entry) r_skid <= i_dat;
    end
  end

  assign o_rdy      = r_rdy;
  assign o_m_vld    = (r_state != ST_EMPTY);
  assign o_skid_dat = r_skid;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid/ready handshake,
// optional two-entry skid buffer, synchronous flush and bubble counter.
// Ports:
//   pipe_stage_reg_clk_i / _rst_n_i   clock, async active-low reset
//   pipe_stage_reg_vld_i / _rdy_o     upstream handshake
//   pipe_stage_reg_dat_i              NFIELD packed fields of DATA_W bits
//   pipe_stage_reg_clr_i              synchronous flush (bubble insertion)
//   pipe_stage_reg_vld_o / _rdy_i     downstream handshake
//   pipe_stage_reg_dat_o              registered packed fields
//   pipe_stage_reg_bub_o              saturating count of cycles with vld_o=0
module pipe_stage_reg
  import cpu_pkg::*;
#(
  parameter int          DATA_W = DATA_W_DEFAULT,
  parameter int          NFIELD = 4,
  parameter int          PC_IDX = FLD_PC4,
  parameter logic [31:0] PC_RST = PC_RST_DEFAULT,
  parameter bit          SKID   = 1'b1,
  parameter int          CNT_W  = 16
) (
  input  logic                     pipe_stage_reg_clk_i,
  input  logic                     pipe_stage_reg_rst_n_i,
  input  logic                     pipe_stage_reg_vld_i,
  output logic                     pipe_stage_reg_rdy_o,
  input  logic [NFIELD*DATA_W-1:0] pipe_stage_reg_dat_i,
  input  logic                     pipe_stage_reg_clr_i,
  output logic                     pipe_stage_reg_vld_o,
  input  logic                     pipe_stage_reg_rdy_i,
  output logic [NFIELD*DATA_W-1:0] pipe_stage_reg_dat_o,
  output logic [CNT_W-1:0]         pipe_stage_reg_bub_o
);

  localparam int              W        = NFIELD * DATA_W;
  localparam logic [DATA_W-1:0] PC_RST_T = DATA_W'(PC_RST);

  logic [W-1:0]     w_rst_pat;
  logic [W-1:0]     r_main;
  logic [W-1:0]     w_skid_dat;
  logic             w_vld;
  logic             w_rdy;
  logic             w_ld_in;
  logic             w_ld_skid;
  logic [CNT_W-1:0] r_bub;

  for (genvar k = 0; k < NFIELD; k++) begin : g_pat
    assign w_rst_pat[k*DATA_W +: DATA_W] = (k == PC_IDX) ? PC_RST_T : '0;
  end

  if (SKID) begin : g_skid
    pipe_stage_skid #(.W(W)) u_skid (
      .i_clk      (pipe_stage_reg_clk_i),
      .i_rst_n    (pipe_stage_reg_rst_n_i),
      .i_clr      (pipe_stage_reg_clr_i),
      .i_vld      (pipe_stage_reg_vld_i),
      .i_dat      (pipe_stage_reg_dat_i),
      .i_rdy      (pipe_stage_reg_rdy_i),
      .o_rdy      (w_rdy),
      .o_m_vld    (w_vld),
      .o_ld_in    (w_ld_in),
      .o_ld_skid  (w_ld_skid),
      .o_skid_dat (w_skid_dat)
    );
  end else begin : g_noskid
    logic r_vld;

    // A full register may still accept when the downstream drains it this edge.
    assign w_rdy      = pipe_stage_reg_rdy_i | ~r_vld;
    assign w_ld_in    = pipe_stage_reg_vld_i & w_rdy & ~pipe_stage_reg_clr_i;
    assign w_ld_skid  = 1'b0;
    assign w_skid_dat = '0;
    assign w_vld      = r_vld;

    always_ff @(posedge pipe_stage_reg_clk_i or negedge pipe_stage_reg_rst_n_i) begin
      if (!pipe_stage_reg_rst_n_i) begin
        r_vld <= 1'b0;
      end else if (pipe_stage_reg_clr_i) begin
        r_vld <= 1'b0;
      end else if (pipe_stage_reg_vld_i && w_rdy) begin
        r_vld <= 1'b1;
      end else if (pipe_stage_reg_rdy_i) begin
        r_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge pipe_stage_reg_clk_i or negedge pipe_stage_reg_rst_n_i) begin
    if (!pipe_stage_reg_rst_n_i) begin
      r_main <= w_rst_pat;
    end else if (pipe_stage_reg_clr_i) begin
      r_main <= w_rst_pat;
    end else if (w_ld_skid) begin
      r_main <= w_skid_dat;
    end else if (w_ld_in) begin
      r_main <= pipe_stage_reg_dat_i;
    end
  end

  // Counts flush-induced bubbles too; only reset clears it.
  always_ff @(posedge pipe_stage_reg_clk_i or negedge pipe_stage_reg_rst_n_i) begin
    if (!pipe_stage_reg_rst_n_i) begin
      r_bub <= '0;
    end else if (!w_vld && (r_bub != {CNT_W{1'b1}})) begin
      r_bub <= r_bub + CNT_W'(1);
    end
  end

  assign pipe_stage_reg_rdy_o = w_rdy;
  assign pipe_stage_reg_vld_o = w_vld;
  assign pipe_stage_reg_dat_o = r_main;
  assign pipe_stage_reg_bub_o = r_bub;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised bench for pipe_stage_reg. Three instances share one stimulus:
//   d=0: SKID=1, CNT_W=16    d=1: SKID=0, CNT_W=16    d=2: SKID=1, CNT_W=4
// Each is compared to a FIFO-occupancy reference model.
module tb_pipe_stage_reg;

  localparam int W = 128;
  localparam logic [W-1:0] RST_PAT = {32'h0, 32'h0, 32'h0000_3000, 32'h0};

  logic         clk;
  logic         rst_n;
  logic         vld_i;
  logic         rdy_i;
  logic         clr_i;
  logic [W-1:0] dat_i;

  logic         o_rdy [3];
  logic         o_vld [3];
  logic [W-1:0] o_dat [3];
  logic [15:0]  o_bub [3];
  logic [3:0]   bub_c;

  int checks   = 0;
  int failures = 0;

  // model: up to two queued items per instance, last value left in main register
  int           mn   [3];
  logic [W-1:0] me   [3][2];
  logic [W-1:0] mh   [3];
  int           mb   [3];
  int           bmax [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_stage_reg #(.SKID(1'b1), .CNT_W(16)) u_dut0 (
    .pipe_stage_reg_clk_i(clk), .pipe_stage_reg_rst_n_i(rst_n),
    .pipe_stage_reg_vld_i(vld_i), .pipe_stage_reg_rdy_o(o_rdy[0]),
    .pipe_stage_reg_dat_i(dat_i), .pipe_stage_reg_clr_i(clr_i),
    .pipe_stage_reg_vld_o(o_vld[0]), .pipe_stage_reg_rdy_i(rdy_i),
    .pipe_stage_reg_dat_o(o_dat[0]), .pipe_stage_reg_bub_o(o_bub[0]));

  pipe_stage_reg #(.SKID(1'b0), .CNT_W(16)) u_dut1 (
    .pipe_stage_reg_clk_i(clk), .pipe_stage_reg_rst_n_i(rst_n),
    .pipe_stage_reg_vld_i(vld_i), .pipe_stage_reg_rdy_o(o_rdy[1]),
    .pipe_stage_reg_dat_i(dat_i), .pipe_stage_reg_clr_i(clr_i),
    .pipe_stage_reg_vld_o(o_vld[1]), .pipe_stage_reg_rdy_i(rdy_i),
    .pipe_stage_reg_dat_o(o_dat[1]), .pipe_stage_reg_bub_o(o_bub[1]));

  pipe_stage_reg #(.SKID(1'b1), .CNT_W(4)) u_dut2 (
    .pipe_stage_reg_clk_i(clk), .pipe_stage_reg_rst_n_i(rst_n),
    .pipe_stage_reg_vld_i(vld_i), .pipe_stage_reg_rdy_o(o_rdy[2]),
    .pipe_stage_reg_dat_i(dat_i), .pipe_stage_reg_clr_i(clr_i),
    .pipe_stage_reg_vld_o(o_vld[2]), .pipe_stage_reg_rdy_i(rdy_i),
    .pipe_stage_reg_dat_o(o_dat[2]), .pipe_stage_reg_bub_o(bub_c));

  assign o_bub[2] = {12'h0, bub_c};

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      mn[d] = 0;
      mh[d] = RST_PAT;
      mb[d] = 0;
    end
  endtask

  function automatic logic model_rdy(int d);
    if (d == 1) return rdy_i || (mn[d] == 0);
    return mn[d] < 2;
  endfunction

  // One clock edge of the reference model with the inputs currently applied.
  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      logic up;
      up = vld_i && model_rdy(d);
      if (mn[d] == 0 && mb[d] < bmax[d]) mb[d]++;
      if (clr_i) begin
        mn[d] = 0;
        mh[d] = RST_PAT;
      end else begin
        if (mn[d] > 0 && rdy_i) begin
          mh[d]    = me[d][0];
          me[d][0] = me[d][1];
          mn[d]--;
        end
        if (up) begin
          me[d][mn[d]] = dat_i;
          mn[d]++;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      logic [W-1:0] exp_dat;
      string sfx;
      sfx = $sformatf("[%0d]", d);
      exp_dat = (mn[d] > 0) ? me[d][0] : mh[d];
      chk({"vld_o", sfx}, W'(o_vld[d]), W'(mn[d] > 0));
      chk({"rdy_o", sfx}, W'(o_rdy[d]), W'(model_rdy(d)));
      chk({"dat_o", sfx}, o_dat[d], exp_dat);
      chk({"bub_o", sfx}, W'(o_bub[d]), W'(mb[d]));
    end
  endtask

  // Apply inputs just after a rising edge, check mid-cycle, then clock the model.
  task automatic step(input logic rst, input logic v, input logic r,
                      input logic c, input logic [W-1:0] dv);
    rst_n = rst;
    vld_i = v;
    rdy_i = r;
    clr_i = c;
    dat_i = dv;
    if (!rst) model_reset();
    @(negedge clk);
    check_all();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  function automatic logic [W-1:0] rnd_dat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    bmax[0] = 65535;
    bmax[1] = 65535;
    bmax[2] = 15;
    model_reset();
    rst_n = 1'b0; vld_i = 1'b0; rdy_i = 1'b0; clr_i = 1'b0; dat_i = '0;
    #1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    // streaming
    step(1'b1, 1'b1, 1'b1, 1'b0, W'(128'h11));
    step(1'b1, 1'b1, 1'b1, 1'b0, W'(128'h22));
    step(1'b1, 1'b1, 1'b1, 1'b0, W'(128'h33));
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    // backpressure then drain
    step(1'b1, 1'b1, 1'b0, 1'b0, W'(128'h0A));
    step(1'b1, 1'b1, 1'b0, 1'b0, W'(128'h0B));
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    // fill, then flush with a coincident upstream beat
    step(1'b1, 1'b1, 1'b0, 1'b0, W'(128'h5A));
    step(1'b1, 1'b1, 1'b0, 1'b0, W'(128'h5B));
    step(1'b1, 1'b1, 1'b0, 1'b1, W'(128'hFF));
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    // long idle saturates the narrow counter; flush must not clear it
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 1'b1, '0);
    step(1'b1, 1'b0, 1'b1, 1'b0, '0);
    // random traffic with a reset in the middle
    for (int i = 0; i < 400; i++) begin
      logic rs;
      rs = !(i >= 200 && i < 202);
      step(rs, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 31) == 0), rnd_dat());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
